// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and sizing helpers for the R2SDF FFT pipeline.
package fft_pkg;
   localparam int FFT_DATA_W    = 33;
   localparam int FFT_MAX_DEPTH = 32;
   function automatic int clog2(input int v);
      int r;
      for (r = 0; (1 << r) < v; r++) begin
      end
      return r;
   endfunction
endpackage

// File: rtl/sdf_ram_rbw.sv
// sdf_ram_rbw: single-clock RAM, shared read/write address, read-before-write.
module sdf_ram_rbw
   import fft_pkg::*;
#(
   parameter int W     = 2 * FFT_DATA_W,
   parameter int DEPTH = FFT_MAX_DEPTH,
   parameter int AW    = clog2(DEPTH)
) (
   input  logic          iClk,
   input  logic          iWe,
   input  logic [AW-1:0] iAddr,
   input  logic [W-1:0]  iWdata,
   output logic [W-1:0]  oRdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge iClk) begin
      if (iWe) mem[iAddr] <= iWdata;
   end
   // Asynchronous read returns the old word during a write, giving read-before-write.
   assign oRdata = mem[iAddr];
endmodule

// File: rtl/sdf_delay_line.sv
// sdf_delay_line: run-time-programmable complex delay line on a circular RAM.
module sdf_delay_line
   import fft_pkg::*;
#(
   parameter int DATA_W    = FFT_DATA_W,
   parameter int MAX_DEPTH = FFT_MAX_DEPTH,
   parameter int DEPTH_W   = clog2(MAX_DEPTH) + 1
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iEn,
   input  logic               iFlush,
   input  logic [DEPTH_W-1:0] iDepth,
   input  logic [DATA_W-1:0]  iData_Re,
   input  logic [DATA_W-1:0]  iData_Im,
   output logic [DATA_W-1:0]  oData_Re,
   output logic [DATA_W-1:0]  oData_Im,
   output logic               oValid,
   output logic               oPrimed,
   output logic               oCfgErr
);
   localparam int AW = clog2(MAX_DEPTH);
   localparam logic [DEPTH_W-1:0] MAXD = DEPTH_W'(MAX_DEPTH);

   logic [AW-1:0]      ptr_q, ptr_d;
   logic [DEPTH_W-1:0] fill_q, fill_d, depth_q, depth_d;
   logic [DATA_W-1:0]  re_q, re_d, im_q, im_d;
   logic               valid_q, valid_d, primed_q, primed_d, err_q, err_d, pend_q, pend_d;
   logic               cfg, push, bad, full, wrap;
   logic [2*DATA_W-1:0] rd;

   sdf_ram_rbw #(.W(2 * DATA_W), .DEPTH(MAX_DEPTH), .AW(AW)) u_ram (
      .iClk   (iClk),
      .iWe    (push),
      .iAddr  (ptr_q),
      .iWdata ({iData_Re, iData_Im}),
      .oRdata (rd)
   );

   // The first edge after reset release latches the depth exactly like a flush.
   always_comb begin
      cfg      = pend_q || iFlush;
      push     = iEn && !cfg;
      bad      = (iDepth == '0) || (iDepth > MAXD);
      full     = fill_q == depth_q;
      wrap     = ptr_q == AW'(depth_q - DEPTH_W'(1));
      pend_d   = 1'b0;
      depth_d  = cfg ? (bad ? MAXD : iDepth) : depth_q;
      err_d    = cfg ? bad : err_q;
      ptr_d    = cfg ? '0 : push ? (wrap ? '0 : ptr_q + AW'(1)) : ptr_q;
      fill_d   = cfg ? '0 : (push && !full) ? fill_q + DEPTH_W'(1) : fill_q;
      valid_d  = cfg ? 1'b0 : push ? full : valid_q;
      re_d     = cfg ? '0 : push ? (full ? rd[2*DATA_W-1:DATA_W] : '0) : re_q;
      im_d     = cfg ? '0 : push ? (full ? rd[DATA_W-1:0] : '0) : im_q;
      primed_d = fill_d == depth_d;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         ptr_q    <= '0;
         fill_q   <= '0;
         depth_q  <= MAXD;
         re_q     <= '0;
         im_q     <= '0;
         valid_q  <= 1'b0;
         primed_q <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= 1'b1;
      end else begin
         ptr_q    <= ptr_d;
         fill_q   <= fill_d;
         depth_q  <= depth_d;
         re_q     <= re_d;
         im_q     <= im_d;
         valid_q  <= valid_d;
         primed_q <= primed_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
      end
   end

   assign oData_Re = re_q;
   assign oData_Im = im_q;
   assign oValid   = valid_q;
   assign oPrimed  = primed_q;
   assign oCfgErr  = err_q;
endmodule

// File: tb/tb_sdf_delay_line.sv
// tb_sdf_delay_line: directed plus random checks against a FIFO-based reference model.
module tb_sdf_delay_line;
   logic        iClk = 1'b0, iRst_n = 1'b0, iEn = 1'b0, iFlush = 1'b0;
   logic [5:0]  iDepth = 6'd32;
   logic [32:0] iData_Re = '0, iData_Im = '0;
   logic [32:0] oData_Re, oData_Im;
   logic        oValid, oPrimed, oCfgErr;
   int          n_vec = 0, n_err = 0;

   // Reference model: queue of samples pushed since last flush/reset.
   logic [65:0] hist [$];
   int          m_depth = 32;
   logic        m_err = 1'b0, m_valid = 1'b0, m_pend = 1'b1;
   logic [32:0] m_re = '0, m_im = '0;

   sdf_delay_line dut (
      .iClk(iClk), .iRst_n(iRst_n), .iEn(iEn), .iFlush(iFlush), .iDepth(iDepth),
      .iData_Re(iData_Re), .iData_Im(iData_Im), .oData_Re(oData_Re), .oData_Im(oData_Im),
      .oValid(oValid), .oPrimed(oPrimed), .oCfgErr(oCfgErr)
   );

   always #5 iClk = ~iClk;

   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all();
      chk("re", oData_Re, m_re);
      chk("im", oData_Im, m_im);
      chk("valid", 33'(oValid), 33'(m_valid));
      chk("primed", 33'(oPrimed), 33'(hist.size() == m_depth));
      chk("cfgerr", 33'(oCfgErr), 33'(m_err));
   endtask

   task automatic model_reset();
      hist.delete();
      m_depth = 32; m_err = 1'b0; m_valid = 1'b0; m_pend = 1'b1; m_re = '0; m_im = '0;
   endtask

   task automatic model_edge(input logic en, input logic fl, input logic [5:0] dep,
                             input logic [32:0] re, input logic [32:0] im);
      logic [65:0] w;
      if (!iRst_n) return;
      if (m_pend || fl) begin
         m_pend = 1'b0;
         m_err = (dep == 0) || (dep > 32);
         m_depth = m_err ? 32 : int'(dep);
         hist.delete();
         m_re = '0; m_im = '0; m_valid = 1'b0;
      end else if (en) begin
         hist.push_back({re, im});
         if (hist.size() > m_depth) begin
            w = hist.pop_front();
            m_re = w[65:33]; m_im = w[32:0]; m_valid = 1'b1;
         end else begin
            m_re = '0; m_im = '0; m_valid = 1'b0;
         end
      end
   endtask

   task automatic cyc(input logic en, input logic fl, input logic [5:0] dep,
                      input logic [32:0] re, input logic [32:0] im);
      iEn = en; iFlush = fl; iDepth = dep; iData_Re = re; iData_Im = im;
      @(posedge iClk);
      model_edge(en, fl, dep, re, im);
      #1;
      chk_all();
   endtask

   function automatic logic [32:0] rnd33();
      return {1'($urandom()), 32'($urandom())};
   endfunction

   initial begin
      // Reset held with iEn toggling: outputs stay zero.
      #1;
      for (int i = 0; i < 4; i++) cyc(1'(i % 2), 1'b0, 6'd32, rnd33(), rnd33());
      iRst_n = 1'b1;
      cyc(1'b0, 1'b0, 6'd32, '0, '0);
      // Depth 32: push 1..40.
      for (int k = 1; k <= 40; k++) begin
         cyc(1'b1, 1'b0, 6'd5, 33'(k), 33'(1000 + k));
         if (k == 31) chk("primed_31", 33'(oPrimed), 33'd0);
         if (k == 32) chk("primed_32", 33'(oPrimed), 33'd1);
         if (k == 33) chk("push33", oData_Re, 33'd1);
         if (k == 40) chk("push40", oData_Re, 33'd8);
      end
      // Flush to depth 4 alongside a push of 99, which must be discarded.
      cyc(1'b1, 1'b1, 6'd4, 33'd99, 33'd99);
      for (int k = 1; k <= 6; k++) begin
         cyc(1'b1, 1'b0, 6'd17, 33'(k), 33'(k));
         chk("flush4_out", oData_Re, (k > 4) ? 33'(k - 4) : 33'd0);
      end
      // Enable gaps on depth 4: output frozen while iEn is low.
      for (int k = 7; k <= 10; k++) begin
         cyc(1'b0, 1'b0, 6'd4, 33'd777, 33'd777);
         chk("gap_hold", oData_Re, 33'(k - 5));
         cyc(1'b1, 1'b0, 6'd4, 33'(k), 33'(k));
         chk("gap_push", oData_Re, 33'(k - 4));
      end
      // Illegal depths clamp to 32, legal 8 clears the error; depth 1 too.
      cyc(1'b0, 1'b1, 6'd0, '0, '0);
      chk("err_0", 33'(oCfgErr), 33'd1);
      for (int k = 0; k < 34; k++) cyc(1'b1, 1'b0, 6'd3, rnd33(), rnd33());
      cyc(1'b0, 1'b1, 6'd40, '0, '0);
      chk("err_40", 33'(oCfgErr), 33'd1);
      for (int k = 0; k < 34; k++) cyc(1'b1, 1'b0, 6'd3, rnd33(), rnd33());
      cyc(1'b0, 1'b1, 6'd1, '0, '0);
      for (int k = 1; k <= 5; k++) begin
         cyc(1'b1, 1'b0, 6'd1, 33'(k), 33'(k));
         chk("depth1", oData_Re, (k > 1) ? 33'(k - 1) : 33'd0);
      end
      cyc(1'b0, 1'b1, 6'd8, '0, '0);
      chk("err_8", 33'(oCfgErr), 33'd0);
      for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 6'd8, rnd33(), rnd33());
      // Asynchronous reset mid-stream at depth 8.
      iRst_n = 1'b0;
      #1;
      model_reset();
      chk_all();
      cyc(1'b1, 1'b0, 6'd8, rnd33(), rnd33());
      iRst_n = 1'b1;
      cyc(1'b0, 1'b0, 6'd8, '0, '0);
      for (int k = 0; k < 20; k++) cyc(1'b1, 1'b0, 6'd2, rnd33(), rnd33());
      // Random traffic with occasional flushes and iDepth churn.
      for (int k = 0; k < 400; k++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 30) == 0),
             6'($urandom_range(0, 40)), rnd33(), rnd33());
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
